sa_matmul_tile: RTL and testbench

//  Rectangular ROWS x COLS output-stationary systolic matmul tile with its own sequencer. Computes C = A(ROWSxK) * B(KxCOLS)
//  for a run-time K. Contains the operand skew registers, a valid/ready input stream, and a row-by-row result drain.

---
 rtl/sa_pkg.sv | 45 ++++
 rtl/sa_pe.sv | 76 +++++++
 rtl/sa_matmul_tile.sv | 240 ++++++++++++++++++++++++
 tb/tb_sa_matmul_tile.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and helpers for the sa_matmul_tile systolic tile.
// Provides the sequencer states, the reduction-depth width helper and the saturating adder.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        FLUSH,
        DRAIN
    } sa_state_e;

    // Widest accumulator the saturating adder supports.
    localparam int SA_MAXW = 64;

    function automatic int k_width(input int kmax);
        return $clog2(kmax + 1);
    endfunction

    // Adds two sign-extended values and clamps the result to an acc_w-bit signed range.
    function automatic logic signed [SA_MAXW-1:0] sat_add(
        input  logic signed [SA_MAXW-1:0] acc,
        input  logic signed [SA_MAXW-1:0] prod,
        input  int                        acc_w,
        output logic                      clamp
    );
        logic signed [SA_MAXW:0] sum;
        logic signed [SA_MAXW:0] one;
        logic signed [SA_MAXW:0] hi;
        logic signed [SA_MAXW:0] lo;
        one     = 1;
        sum     = $signed({acc[SA_MAXW-1], acc}) + $signed({prod[SA_MAXW-1], prod});
        hi      = (one <<< (acc_w - 1)) - one;
        lo      = -(one <<< (acc_w - 1));
        clamp   = 1'b0;
        sat_add = sum[SA_MAXW-1:0];
        if (sum > hi) begin
            clamp   = 1'b1;
            sat_add = hi[SA_MAXW-1:0];
        end else if (sum < lo) begin
            clamp   = 1'b1;
            sat_add = lo[SA_MAXW-1:0];
        end
    endfunction

endpackage

// File: rtl/sa_pe.sv
// One output-stationary MAC cell: forwards A right and B down with their tags, accumulates in place.
// SA_SATURATE_EN selects a clamping accumulator with a sticky overflow flag; otherwise it wraps.
module sa_pe
    import sa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] a,
    input  logic                    a_vld,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    b_vld,
    output logic signed [WIDTH-1:0] a_fwd,
    output logic                    a_fwd_vld,
    output logic signed [WIDTH-1:0] b_fwd,
    output logic                    b_fwd_vld,
    output logic signed [ACC-1:0]   acc,
    output logic                    ovf
);

    logic signed [2*WIDTH-1:0] prod_p0;
    logic signed [ACC-1:0]     acc_nxt_p0;
    logic                      mac_p0;

    assign prod_p0 = a * b;
    assign mac_p0  = a_vld && b_vld;

`ifdef SA_SATURATE_EN
    logic signed [SA_MAXW-1:0] sat_p0;
    logic                      clamp_p0;

    always_comb begin
        sat_p0 = sat_add(SA_MAXW'(acc), SA_MAXW'(prod_p0), ACC, clamp_p0);
    end

    assign acc_nxt_p0 = sat_p0[ACC-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (clear) begin
            ovf <= 1'b0;
        end else if (mac_p0 && clamp_p0) begin
            ovf <= 1'b1;
        end
    end
`else
    assign acc_nxt_p0 = acc + ACC'(prod_p0);
    assign ovf        = 1'b0;
`endif

    // p0 -> p1: forward registers and accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_fwd     <= '0;
            a_fwd_vld <= 1'b0;
            b_fwd     <= '0;
            b_fwd_vld <= 1'b0;
            acc       <= '0;
        end else begin
            a_fwd     <= a;
            a_fwd_vld <= a_vld;
            b_fwd     <= b;
            b_fwd_vld <= b_vld;
            if (clear) begin
                acc <= '0;
            end else if (mac_p0) begin
                acc <= acc_nxt_p0;
            end
        end
    end

endmodule

// File: rtl/sa_matmul_tile.sv
// ROWS x COLS output-stationary systolic matmul tile with operand skew, FEED/FLUSH/DRAIN sequencer and row drain.
// Define SA_SATURATE_EN to build saturating accumulators with a sticky ovf flag.
module sa_matmul_tile
    import sa_pkg::*;
#(
    parameter int  ROWS  = 4,
    parameter int  COLS  = 4,
    parameter int  WIDTH = 8,
    parameter int  ACC   = 32,
    parameter int  KMAX  = 256,
    localparam int K_W   = k_width(KMAX),
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [K_W-1:0]                 k_len,
    output logic                           busy,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ROWS-1:0][WIDTH-1:0]     a_data,
    input  logic [COLS-1:0][WIDTH-1:0]     b_data,
    output logic                           c_valid,
    input  logic                           c_ready,
    output logic [COLS-1:0][ACC-1:0]       c_data,
    output logic [ROW_W-1:0]               c_row,
    output logic                           done,
    output logic                           ovf
);

    localparam int              FL_W       = $clog2(ROWS + COLS);
    localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(ROWS + COLS - 2);

    sa_state_e        state_q, state_d;
    logic [K_W-1:0]   k_lat;
    logic [K_W-1:0]   beat_cnt;
    logic [FL_W-1:0]  flush_cnt;
    logic             beat;
    logic             job_start;
    logic             drain_load;
    logic             drain_zero;
    logic             drain_stop;
    logic [ROW_W-1:0] drain_sel;

    logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] a_h;
    logic [ROWS-1:0][COLS-1:0]            a_h_vld;
    logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] b_v;
    logic [ROWS-1:0][COLS-1:0]            b_v_vld;
    logic [ROWS-1:0][COLS-1:0][ACC-1:0]   acc_grid;
    logic [ROWS-1:0][COLS-1:0]            ovf_grid;
    logic [ROWS-1:0][WIDTH-1:0]           a_edge_unused;
    logic [ROWS-1:0]                      a_edge_vld_unused;
    logic [COLS-1:0][WIDTH-1:0]           b_edge_unused;
    logic [COLS-1:0]                      b_edge_vld_unused;

    assign busy     = (state_q != IDLE);
    assign in_ready = (state_q == FEED);
    assign beat     = in_valid && in_ready;
    assign ovf      = |ovf_grid;

    always_comb begin
        state_d    = state_q;
        job_start  = 1'b0;
        drain_load = 1'b0;
        drain_zero = 1'b0;
        drain_stop = 1'b0;
        drain_sel  = '0;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    job_start = 1'b1;
                    if (k_len == '0) begin
                        state_d    = DRAIN;
                        drain_load = 1'b1;
                        drain_zero = 1'b1;
                    end else begin
                        state_d = FEED;
                    end
                end
            end
            FEED: begin
                if (beat && (beat_cnt == k_lat - K_W'(1))) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt == '0) begin
                    state_d    = DRAIN;
                    drain_load = 1'b1;
                end
            end
            DRAIN: begin
                if (c_valid && c_ready) begin
                    if (c_row == ROW_W'(ROWS - 1)) begin
                        done       = 1'b1;
                        drain_stop = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        drain_load = 1'b1;
                        drain_sel  = c_row + ROW_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            k_lat     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            c_valid   <= 1'b0;
            c_row     <= '0;
            c_data    <= '0;
        end else begin
            state_q <= state_d;
            if (job_start) begin
                k_lat    <= k_len;
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + K_W'(1);
            end
            if (state_q != FLUSH) begin
                flush_cnt <= FLUSH_LAST;
            end else begin
                flush_cnt <= flush_cnt - FL_W'(1);
            end
            // Registered drain: c_data/c_row only change on a load, so they hold while stalled.
            if (drain_load) begin
                c_valid <= 1'b1;
                c_row   <= drain_sel;
                c_data  <= drain_zero ? '0 : acc_grid[drain_sel];
            end else if (drain_stop) begin
                c_valid <= 1'b0;
            end
        end
    end

    // Skew: lane r of A and lane c of B are delayed r and c cycles; stalls inject tag-0 bubbles.
    for (genvar r = 0; r < ROWS; r++) begin : g_askew
        if (r == 0) begin : g_direct
            assign a_h[r][0]     = a_data[r];
            assign a_h_vld[r][0] = beat;
        end else begin : g_sr
            logic [r-1:0][WIDTH-1:0] sr;
            logic [r-1:0]            sr_vld;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr     <= '0;
                    sr_vld <= '0;
                end else begin
                    sr[0]     <= a_data[r];
                    sr_vld[0] <= beat;
                    for (int i = 1; i < r; i++) begin
                        sr[i]     <= sr[i-1];
                        sr_vld[i] <= sr_vld[i-1];
                    end
                end
            end
            assign a_h[r][0]     = sr[r-1];
            assign a_h_vld[r][0] = sr_vld[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_bskew
        if (c == 0) begin : g_direct
            assign b_v[0][c]     = b_data[c];
            assign b_v_vld[0][c] = beat;
        end else begin : g_sr
            logic [c-1:0][WIDTH-1:0] sr;
            logic [c-1:0]            sr_vld;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr     <= '0;
                    sr_vld <= '0;
                end else begin
                    sr[0]     <= b_data[c];
                    sr_vld[0] <= beat;
                    for (int i = 1; i < c; i++) begin
                        sr[i]     <= sr[i-1];
                        sr_vld[i] <= sr_vld[i-1];
                    end
                end
            end
            assign b_v[0][c]     = sr[c-1];
            assign b_v_vld[0][c] = sr_vld[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic signed [WIDTH-1:0] a_o;
            logic                    a_o_vld;
            logic signed [WIDTH-1:0] b_o;
            logic                    b_o_vld;
            logic signed [ACC-1:0]   acc_o;

            sa_pe #(
                .WIDTH(WIDTH),
                .ACC  (ACC)
            ) u_pe (
                .clk      (clk),
                .rst      (rst),
                .clear    (job_start),
                .a        ($signed(a_h[r][c])),
                .a_vld    (a_h_vld[r][c]),
                .b        ($signed(b_v[r][c])),
                .b_vld    (b_v_vld[r][c]),
                .a_fwd    (a_o),
                .a_fwd_vld(a_o_vld),
                .b_fwd    (b_o),
                .b_fwd_vld(b_o_vld),
                .acc      (acc_o),
                .ovf      (ovf_grid[r][c])
            );

            assign acc_grid[r][c] = acc_o;

            if (c < COLS - 1) begin : g_a_next
                assign a_h[r][c+1]     = a_o;
                assign a_h_vld[r][c+1] = a_o_vld;
            end else begin : g_a_edge
                assign a_edge_unused[r]     = a_o;
                assign a_edge_vld_unused[r] = a_o_vld;
            end

            if (r < ROWS - 1) begin : g_b_next
                assign b_v[r+1][c]     = b_o;
                assign b_v_vld[r+1][c] = b_o_vld;
            end else begin : g_b_edge
                assign b_edge_unused[c]     = b_o;
                assign b_edge_vld_unused[c] = b_o_vld;
            end
        end
    end

endmodule

// File: tb/tb_sa_matmul_tile.sv
// Directed bench for sa_matmul_tile: a 2x2 ACC=32 instance and a 4x4 ACC=16 instance on one clock.
module tb_sa_matmul_tile;

    localparam int R   = 4;
    localparam int C   = 4;
    localparam int W   = 8;
    localparam int AW  = 16;
    localparam int K_W = 9;

    logic clk = 1'b0;
    logic rst;

    logic                  start, busy, in_valid, in_ready, c_valid, c_ready, done, ovf;
    logic [K_W-1:0]        k_len;
    logic [R-1:0][W-1:0]   a_data;
    logic [C-1:0][W-1:0]   b_data;
    logic [C-1:0][AW-1:0]  c_data;
    logic [1:0]            c_row;

    logic                  s_start, s_busy, s_in_valid, s_in_ready, s_c_valid, s_c_ready, s_done, s_ovf;
    logic [K_W-1:0]        s_k_len;
    logic [1:0][W-1:0]     s_a, s_b;
    logic [1:0][31:0]      s_c_data;
    logic [0:0]            s_c_row;

    int          checks, failures;
    int          opa[16][4];
    int          opb[16][4];
    logic [63:0] exp_row[4];
    logic        exp_ovf;

    always #5 clk = ~clk;

    sa_matmul_tile #(.ROWS(R), .COLS(C), .WIDTH(W), .ACC(AW), .KMAX(256)) dut4 (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data),
        .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data), .c_row(c_row),
        .done(done), .ovf(ovf)
    );

    sa_matmul_tile #(.ROWS(2), .COLS(2), .WIDTH(8), .ACC(32), .KMAX(256)) dut2 (
        .clk(clk), .rst(rst), .start(s_start), .k_len(s_k_len), .busy(s_busy),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .a_data(s_a), .b_data(s_b),
        .c_valid(s_c_valid), .c_ready(s_c_ready), .c_data(s_c_data), .c_row(s_c_row),
        .done(s_done), .ovf(s_ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Golden matmul over the first k operand beats, wrapping or clamping at 16 bits.
    task automatic build_exp(input int k);
        exp_ovf = 1'b0;
        for (int r = 0; r < R; r++) begin
            exp_row[r] = '0;
            for (int c = 0; c < C; c++) begin
                int s;
                s = 0;
                for (int i = 0; i < k; i++) begin
                    s = s + opa[i][r] * opb[i][c];
`ifdef SA_SATURATE_EN
                    if (s > 32767) begin
                        s = 32767;
                        exp_ovf = 1'b1;
                    end else if (s < -32768) begin
                        s = -32768;
                        exp_ovf = 1'b1;
                    end
`endif
                end
                exp_row[r][c*AW +: AW] = 16'(s);
            end
        end
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 4; j++) begin
                case (mode)
                    0: begin opa[i][j] = (j + 1) * (i + 2) - 7; opb[i][j] = 3 * j - 2 * i + 1; end
                    1: begin opa[i][j] = 1;                     opb[i][j] = 1;                 end
                    2: begin opa[i][j] = -128;                  opb[i][j] = -128;              end
                    default: begin opa[i][j] = i - j;           opb[i][j] = 2 * j + i - 5;     end
                endcase
            end
        end
    endtask

    // vmode: 0 valid always, 1 toggling; rmode: 0 ready always, 1 random; smode: 0 pulse, 1 extra pulses, 2 held.
    task automatic run_job(input int k, input int vmode, input int rmode, input int smode);
        int          bi, row, first_cv;
        logic        fin, prev_stall;
        logic [63:0] prev_data;
        logic [1:0]  prev_row;
        build_exp(k);
        bi = 0; row = 0; first_cv = -1; fin = 1'b0; prev_stall = 1'b0;
        prev_data = '0; prev_row = '0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            start    = (cyc == 0) || (smode == 2) || (smode == 1 && (cyc % 3) == 1);
            k_len    = K_W'(k);
            in_valid = (vmode == 0) ? 1'b1 : ((cyc % 2) == 1);
            for (int r = 0; r < R; r++) a_data[r] = (bi < k) ? 8'(opa[bi][r]) : 8'($urandom);
            for (int c = 0; c < C; c++) b_data[c] = (bi < k) ? 8'(opb[bi][c]) : 8'($urandom);
            c_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (cyc == 0) check("busy_before_start", busy, 0);
            if (cyc == 1) begin
                check("busy_after_start", busy, 1);
                check("ovf_cleared", ovf, 0);
            end
            if (in_valid && in_ready) begin
                check("beat_within_k", bi < k, 1);
                bi++;
            end
            if (prev_stall) begin
                check("hold_valid", c_valid, 1);
                check("hold_data", c_data, prev_data);
                check("hold_row", c_row, prev_row);
            end
            if (c_valid && first_cv < 0) begin
                first_cv = cyc;
                if (vmode == 0 && k > 0) check("first_valid_latency", first_cv, k + R + C);
            end
            if (c_valid && c_ready) begin
                check("c_row", c_row, row);
                check("c_data", c_data, exp_row[row]);
                check("done_pulse", done, row == R - 1);
                row++;
                if (row == R) fin = 1'b1;
            end else begin
                check("done_quiet", done, 0);
            end
            prev_stall = c_valid && !c_ready;
            prev_data  = c_data;
            prev_row   = c_row;
        end
        check("job_completed", fin, 1);
        check("beats_accepted", bi, k);
    endtask

    task automatic idle_check();
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("idle_busy", busy, 0);
        check("idle_c_valid", c_valid, 0);
        check("idle_ovf", ovf, exp_ovf);
    endtask

    initial begin
        int          first, nrow, dcount;
        logic [63:0] exp2[2];
        checks = 0; failures = 0;
        rst = 1'b1;
        start = 1'b0; k_len = '0; in_valid = 1'b0; c_ready = 1'b0; a_data = '0; b_data = '0;
        s_start = 1'b0; s_k_len = '0; s_in_valid = 1'b0; s_c_ready = 1'b0; s_a = '0; s_b = '0;
        exp_ovf = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_c_valid", c_valid, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_c_data", c_data, 0);
        check("rst_c_row", c_row, 0);
        check("rst_s_busy", s_busy, 0);
        check("rst_s_in_ready", s_in_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        // 2x2, A=[[1,2],[3,4]], B=I
        exp2[0] = {32'd2, 32'd1};
        exp2[1] = {32'd4, 32'd3};
        first = -1; nrow = 0; dcount = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            s_start    = (cyc == 0);
            s_k_len    = K_W'(2);
            s_in_valid = (cyc == 1) || (cyc == 2);
            s_a        = (cyc == 1) ? {8'd3, 8'd1} : (cyc == 2) ? {8'd4, 8'd2} : 16'd0;
            s_b        = (cyc == 1) ? {8'd0, 8'd1} : (cyc == 2) ? {8'd1, 8'd0} : 16'd0;
            s_c_ready  = 1'b1;
            #1;
            if (s_c_valid && first < 0) first = cyc;
            if (s_c_valid && nrow < 2) begin
                check("t1_c_row", s_c_row, nrow);
                check("t1_c_data", s_c_data, exp2[nrow]);
                nrow++;
            end
            if (s_done) dcount++;
        end
        check("t1_latency", first, 6);
        check("t1_rows", nrow, 2);
        check("t1_done_count", dcount, 1);
        check("t1_ovf", s_ovf, 0);
        check("t1_idle", s_busy, 0);

        // 4x4 k=3 with toggling valid and random ready
        fill(0);
        run_job(3, 1, 1, 0);
        idle_check();

        // k=0 with extra start pulses while busy
        run_job(0, 0, 1, 1);
        idle_check();

        // reset during FLUSH, then a clean all-ones job
        fill(3);
        @(negedge clk);
        start = 1'b1; k_len = K_W'(2); in_valid = 1'b1; c_ready = 1'b1;
        for (int r = 0; r < R; r++) a_data[r] = 8'(opa[0][r]);
        for (int c = 0; c < C; c++) b_data[c] = 8'(opb[0][c]);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("t4_in_flush", {busy, in_ready}, 2'b10);
        rst = 1'b1;
        #1;
        check("t4_rst_busy", busy, 0);
        check("t4_rst_c_valid", c_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        fill(1);
        run_job(4, 0, 0, 0);
        idle_check();

        // overflow: every operand -128, k=3, 16-bit accumulators
        fill(2);
        run_job(3, 0, 0, 0);
        idle_check();

        // back-to-back jobs with start held and c_ready tied high
        fill(0);
        run_job(2, 0, 0, 2);
        run_job(3, 0, 0, 2);
        idle_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
